// File: rtl/md_seq_unit.sv
// Iterative unsigned multiply/divide unit with a start/busy/done handshake.
// Results are held in hi/lo. Opcodes other than MUL/DIV pass operand a through to b.
//
// Handshake: a start is accepted on a rising edge when start=1, the opcode is
// OP_MUL or OP_DIV and the unit is not busy (IDLE or DONE). busy is high for W cycles.
// done then pulses for one cycle. A start while busy, or with another opcode, is dropped.
module md_seq_unit #(
   parameter int         W      = 8,
   parameter logic [5:0] OP_MUL = 6'b000010,
   parameter logic [5:0] OP_DIV = 6'b000100
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [5:0]   opcode,
   input  logic [W-1:0] a,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic [W-1:0] b,
   output logic         check,
   output logic         div_zero,
   output logic [1:0]   fsm_state
);

   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [CW-1:0] cnt;
   logic          is_div;
   logic [W-1:0]  acc_hi;
   logic [W-1:0]  acc_lo;
   logic [W-1:0]  m;

   logic          op_valid;
   logic          accept;
   logic          last_iter;

   logic [W:0]    mul_sum;
   logic [W-1:0]  mul_hi_nx;
   logic [W-1:0]  mul_lo_nx;
   logic [W:0]    div_sh;
   logic          div_ge;
   logic [W-1:0]  div_diff;
   logic [W-1:0]  div_hi_nx;
   logic [W-1:0]  div_lo_nx;
   logic [W-1:0]  step_hi;
   logic [W-1:0]  step_lo;

   assign op_valid  = (opcode == OP_MUL) || (opcode == OP_DIV);
   assign accept    = start && op_valid && (state != S_RUN);
   assign last_iter = (state == S_RUN) && (cnt == LAST);
   assign fsm_state = state;

   // Pass-through path is purely combinational and independent of the FSM
   assign b = op_valid ? '0 : a;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) state_nx = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (last_iter) state_nx = S_DONE;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = accept ? S_RUN : S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // MUL: {acc_hi,acc_lo} starts as {0,multiplier}. Each step adds the multiplicand
   // to the upper half if the lsb is set, then shifts the whole pair right by one.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
      mul_hi_nx = mul_sum[W:1];
      mul_lo_nx = {mul_sum[0], acc_lo[W-1:1]};
   end

   // DIV: acc_hi holds the partial remainder and acc_lo shifts dividend bits out
   // as quotient bits shift in. With a zero divisor, every trial subtract succeeds,
   // which gives a quotient of all ones and a remainder equal to x.
   always_comb begin
      div_sh    = {acc_hi, acc_lo[W-1]};
      div_ge    = (div_sh >= {1'b0, m});
      div_diff  = div_sh[W-1:0] - m;
      div_hi_nx = div_ge ? div_diff : div_sh[W-1:0];
      div_lo_nx = {acc_lo[W-2:0], div_ge};
   end

   always_comb begin
      step_hi = is_div ? div_hi_nx : mul_hi_nx;
      step_lo = is_div ? div_lo_nx : mul_lo_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         is_div   <= 1'b0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         m        <= '0;
         hi       <= '0;
         lo       <= '0;
         check    <= 1'b0;
         div_zero <= 1'b0;
      end else if (accept) begin
         cnt      <= '0;
         is_div   <= (opcode == OP_DIV);
         acc_hi   <= '0;
         acc_lo   <= (opcode == OP_DIV) ? x : y;
         m        <= (opcode == OP_DIV) ? y : x;
         check    <= 1'b0;
         div_zero <= 1'b0;
      end else if (state == S_RUN) begin
         acc_hi <= step_hi;
         acc_lo <= step_lo;
         cnt    <= cnt + CW'(1);
         if (last_iter) begin
            hi       <= step_hi;
            lo       <= step_lo;
            check    <= 1'b1;
            div_zero <= is_div && (m == '0);
         end
      end
   end

endmodule

// File: tb/tb_md_seq_unit.sv
// Directed bench for md_seq_unit (W=8). It checks latency, MUL/DIV results,
// divide-by-zero, pass-through, ignored starts, back-to-back starts and mid-run reset.
module tb_md_seq_unit;

   localparam int         W      = 8;
   localparam logic [5:0] OP_MUL = 6'b000010;
   localparam logic [5:0] OP_DIV = 6'b000100;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [5:0]   opcode;
   logic [W-1:0] a;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic [W-1:0] b;
   logic         check;
   logic         div_zero;
   logic [1:0]   fsm_state;

   int total = 0;
   int bad   = 0;
   int lat;
   int done_cnt;

   md_seq_unit #(.W(W), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .opcode    (opcode),
      .a         (a),
      .x         (x),
      .y         (y),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo),
      .b         (b),
      .check     (check),
      .div_zero  (div_zero),
      .fsm_state (fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Launch one operation and return in the done cycle, at a falling edge.
   // lat counts cycles from acceptance up to done. It must equal W+1.
   // If b2b is set, start is driven in the current cycle with no extra wait.
   task automatic run_op(input string tag, input logic [5:0] op,
                         input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input bit b2b, output int l);
      if (!b2b) @(negedge clk);
      start  = 1'b1;
      opcode = op;
      x      = xv;
      y      = yv;
      @(negedge clk);
      start = 1'b0;
      x     = W'($urandom_range(0, 255));
      y     = W'($urandom_range(0, 255));
      l     = 1;
      chk({tag, "_busy_first"}, 32'(busy), 32'd1);
      chk({tag, "_check_clr"}, 32'(check), 32'd0);
      chk({tag, "_dz_clr"}, 32'(div_zero), 32'd0);
      while (!done && l < 40) begin
         @(negedge clk);
         l++;
      end
      chk({tag, "_latency"}, 32'(l), 32'(W + 1));
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      opcode = 6'd0;
      a      = '0;
      x      = '0;
      y      = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_check", 32'(check), 32'd0);
      chk("rst_dz", 32'(div_zero), 32'd0);
      chk("rst_hi", 32'(hi), 32'd0);
      chk("rst_lo", 32'(lo), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // MUL 200*150 = 30000 = 0x7530
      run_op("mul1", OP_MUL, 8'd200, 8'd150, 1'b0, lat);
      chk("mul1_hi", 32'(hi), 32'h75);
      chk("mul1_lo", 32'(lo), 32'h30);
      chk("mul1_check", 32'(check), 32'd1);
      chk("mul1_dz", 32'(div_zero), 32'd0);
      @(negedge clk);
      chk("mul1_done_pulse", 32'(done), 32'd0);
      chk("mul1_check_hold", 32'(check), 32'd1);

      // DIV 200/7 = 28 r 4
      run_op("div1", OP_DIV, 8'd200, 8'd7, 1'b0, lat);
      chk("div1_lo", 32'(lo), 32'h1C);
      chk("div1_hi", 32'(hi), 32'h04);
      chk("div1_check", 32'(check), 32'd1);

      // Pass-through, plus a start with a non-MUL/DIV opcode, which must be ignored
      @(negedge clk);
      opcode = 6'd0;
      a      = 8'h3C;
      #1;
      chk("pt_b", 32'(b), 32'h3C);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("pt_busy", 32'(busy), 32'd0);
      chk("pt_hi", 32'(hi), 32'h04);
      chk("pt_lo", 32'(lo), 32'h1C);
      chk("pt_check", 32'(check), 32'd1);
      opcode = OP_MUL;
      #1;
      chk("pt_b_mul", 32'(b), 32'h00);
      opcode = OP_DIV;
      #1;
      chk("pt_b_div", 32'(b), 32'h00);
      opcode = 6'h3F;
      a      = 8'hA5;
      #1;
      chk("pt_b_other", 32'(b), 32'hA5);

      // Divide by zero
      run_op("dz", OP_DIV, 8'h55, 8'd0, 1'b0, lat);
      chk("dz_lo", 32'(lo), 32'hFF);
      chk("dz_hi", 32'(hi), 32'h55);
      chk("dz_flag", 32'(div_zero), 32'd1);
      run_op("mul34", OP_MUL, 8'd3, 8'd4, 1'b0, lat);
      chk("mul34_dz", 32'(div_zero), 32'd0);
      chk("mul34_hi", 32'(hi), 32'h00);
      chk("mul34_lo", 32'(lo), 32'h0C);

      // Second start at cycle 3 of a MUL must be ignored
      @(negedge clk);
      start    = 1'b1;
      opcode   = OP_MUL;
      x        = 8'd200;
      y        = 8'd150;
      done_cnt = 0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 2; i <= 16; i++) begin
         if (i == 3) begin
            start = 1'b1;
            x     = 8'd1;
            y     = 8'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (done) done_cnt++;
      end
      start = 1'b0;
      chk("ign_done_count", 32'(done_cnt), 32'd1);
      chk("ign_hi", 32'(hi), 32'h75);
      chk("ign_lo", 32'(lo), 32'h30);

      // Back-to-back: 15*17 = 255, then DIV 100/9 = 11 r 1 started in the done cycle
      run_op("b2b_mul", OP_MUL, 8'd15, 8'd17, 1'b0, lat);
      chk("b2b_mul_hi", 32'(hi), 32'h00);
      chk("b2b_mul_lo", 32'(lo), 32'hFF);
      run_op("b2b_div", OP_DIV, 8'd100, 8'd9, 1'b1, lat);
      chk("b2b_div_lo", 32'(lo), 32'h0B);
      chk("b2b_div_hi", 32'(hi), 32'h01);

      // Boundary operands
      run_op("mulmax", OP_MUL, 8'hFF, 8'hFF, 1'b0, lat);
      chk("mulmax_hi", 32'(hi), 32'hFE);
      chk("mulmax_lo", 32'(lo), 32'h01);
      run_op("divsame", OP_DIV, 8'hFF, 8'hFF, 1'b0, lat);
      chk("divsame_lo", 32'(lo), 32'h01);
      chk("divsame_hi", 32'(hi), 32'h00);
      run_op("divsmall", OP_DIV, 8'd5, 8'd9, 1'b0, lat);
      chk("divsmall_lo", 32'(lo), 32'h00);
      chk("divsmall_hi", 32'(hi), 32'h05);

      // Reset during cycle 4 of a DIV
      @(negedge clk);
      start  = 1'b1;
      opcode = OP_DIV;
      x      = 8'd200;
      y      = 8'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_done", 32'(done), 32'd0);
      chk("mid_check", 32'(check), 32'd0);
      chk("mid_hi", 32'(hi), 32'd0);
      chk("mid_lo", 32'(lo), 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      chk("mid_no_done", 32'(done_cnt), 32'd0);
      chk("mid_idle_busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
